// File: rtl/spi_regif_burst.sv
// SPI slave register-access port, oversampled on the system clock.
// Synchronises the SPI pins, decodes a 1+ADDR_W bit command word and then
// streams DATA_W bit data words to or from the register file, with optional
// address auto-increment, read prefetch and frame-error reporting.
module spi_regif_burst #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 1,
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] addr_reg,
  output logic [DATA_W-1:0] data_wr,
  output logic              wr_en,
  output logic              rd_en,
  input  logic [DATA_W-1:0] data_rd_i,
  output logic              frame_err
);

  localparam int CMD_W = ADDR_W + 1;
  localparam int RX_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int CNT_W = $clog2(RX_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_d;
  logic                   cs_d;

  logic [CNT_W-1:0]  bit_cnt;
  logic [RX_W-1:0]   rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_armed;
  logic              ld_wait;
  logic              inc_pend;

  logic              sclk_s;
  logic              mosi_s;
  logic              cs_s;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              lead_edge;
  logic              trail_edge;
  logic              sample_edge;
  logic              shift_edge;
  logic              cs_fall;
  logic [RX_W-1:0]   next_rx;
  logic              last_cmd_bit;
  logic              last_data_bit;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_s & cs_d;

  assign next_rx       = {rx_shift[RX_W-2:0], mosi_s};
  assign last_cmd_bit  = (bit_cnt == CNT_W'(CMD_W - 1));
  assign last_data_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  // The tx MSB is only presented once armed and only during a read frame.
  assign miso = (state == RDATA) & tx_armed & tx_shift[DATA_W-1];

  // Bring the asynchronous pins into the clk domain and keep one-clk-old copies for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Frame FSM: command decode, write/read data words, strobes and abort handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_armed  <= 1'b0;
      ld_wait   <= 1'b0;
      inc_pend  <= 1'b0;
      addr_reg  <= '0;
      data_wr   <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      frame_err <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      frame_err <= 1'b0;
      ld_wait   <= 1'b0;
      inc_pend  <= 1'b0;
      miso_oe   <= ~cs_s;
      if (inc_pend) begin
        addr_reg <= addr_reg + ADDR_W'(AUTO_INC);
      end
      if ((state != IDLE) && cs_s) begin
        state     <= IDLE;
        frame_err <= (bit_cnt != '0);
        bit_cnt   <= '0;
        rx_shift  <= '0;
        tx_shift  <= '0;
        tx_armed  <= 1'b0;
        addr_reg  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state    <= CMD;
              bit_cnt  <= '0;
              rx_shift <= '0;
            end
          end
          CMD: begin
            if (sample_edge) begin
              if (last_cmd_bit) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                addr_reg <= next_rx[ADDR_W-1:0];
                if (next_rx[ADDR_W]) begin
                  state <= RDATA;
                  rd_en <= 1'b1;
                end else begin
                  state <= WDATA;
                end
              end else begin
                bit_cnt  <= bit_cnt + CNT_W'(1);
                rx_shift <= next_rx;
              end
            end
          end
          WDATA: begin
            if (sample_edge) begin
              if (last_data_bit) begin
                data_wr  <= next_rx[DATA_W-1:0];
                wr_en    <= 1'b1;
                inc_pend <= 1'b1;
                bit_cnt  <= '0;
                rx_shift <= '0;
              end else begin
                bit_cnt  <= bit_cnt + CNT_W'(1);
                rx_shift <= next_rx;
              end
            end
          end
          RDATA: begin
            ld_wait <= rd_en;
            if (ld_wait) begin
              tx_shift <= data_rd_i;
              tx_armed <= (CPHA == 0);
            end
            if (sample_edge) begin
              if (last_data_bit) begin
                bit_cnt  <= '0;
                addr_reg <= addr_reg + ADDR_W'(AUTO_INC);
                rd_en    <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end else if (shift_edge) begin
              if (bit_cnt == '0) begin
                tx_armed <= 1'b1;
              end else begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_regif_burst.sv
// Bench for spi_regif_burst: five instances covering the four SPI modes and
// AUTO_INC=0, driven by a bit-level SPI master with table-driven frames.
`timescale 1ns/1ps
module tb_spi_regif_burst;

  localparam int NI   = 5;
  localparam int HALF = 8;

  // Instance map: 0 mode1 inc, 1 mode1 no-inc, 2 mode0, 3 mode2, 4 mode3.
  localparam logic [NI-1:0] CPOL_V = 5'b11000;
  localparam logic [NI-1:0] CPHA_V = 5'b10011;
  localparam logic [NI-1:0] INC_V  = 5'b11101;

  typedef struct packed {
    logic [2:0]      inst;
    logic            rd;
    logic [6:0]      addr;
    logic [1:0]      nwords;
    logic [2:0][7:0] wd;
    logic [2:0][6:0] exp_a;
    logic [2:0][7:0] exp_d;
    logic [1:0]      exp_n;
    logic [3:0]      cut;
    logic            exp_ferr;
  } vec_t;

  logic clk;
  logic rst_n;
  logic sclk_base;
  logic mosi;
  logic cs_act;
  int   sel;

  logic       sclk_a      [NI];
  logic       cs_a        [NI];
  logic       miso_a      [NI];
  logic       miso_oe_a   [NI];
  logic [6:0] addr_a      [NI];
  logic [7:0] data_wr_a   [NI];
  logic       wr_en_a     [NI];
  logic       rd_en_a     [NI];
  logic [7:0] data_rd_a   [NI];
  logic       frame_err_a [NI];

  int total;
  int bad;
  int ferr_cnt;
  int overlap_cnt;
  logic [6:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [6:0] rd_addr_q[$];

  vec_t vecs[13];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign sclk_a[g] = sclk_base ^ CPOL_V[g];
    assign cs_a[g]   = ~(cs_act && (sel == g));

    spi_regif_burst #(
      .ADDR_W(7), .DATA_W(8),
      .CPOL(int'(CPOL_V[g])), .CPHA(int'(CPHA_V[g])),
      .SYNC_STAGES(2), .AUTO_INC(int'(INC_V[g]))
    ) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk_a[g]), .mosi(mosi), .cs(cs_a[g]),
      .miso(miso_a[g]), .miso_oe(miso_oe_a[g]), .addr_reg(addr_a[g]),
      .data_wr(data_wr_a[g]), .wr_en(wr_en_a[g]), .rd_en(rd_en_a[g]),
      .data_rd_i(data_rd_a[g]), .frame_err(frame_err_a[g])
    );

    // Register-file model: read data is address + 0x30, valid the clk after rd_en.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_rd_a[g] <= 8'h00;
      else if (rd_en_a[g]) data_rd_a[g] <= {1'b0, addr_a[g]} + 8'h30;
    end
  end

  // Record strobes of the selected instance away from the active edge.
  always @(negedge clk) begin
    if (wr_en_a[sel]) begin
      wr_addr_q.push_back(addr_a[sel]);
      wr_data_q.push_back(data_wr_a[sel]);
    end
    if (rd_en_a[sel]) rd_addr_q.push_back(addr_a[sel]);
    if (frame_err_a[sel]) ferr_cnt++;
    for (int i = 0; i < NI; i++) begin
      if (wr_en_a[i] && rd_en_a[i]) overlap_cnt++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI bit from the master side; r is what the master samples on miso.
  task automatic spiBit(input logic b, input logic cpha, output logic r);
    if (!cpha) begin
      mosi = b;
      waitClk(HALF);
      r = miso_a[sel];
      sclk_base = 1'b1;
      waitClk(HALF);
      sclk_base = 1'b0;
    end else begin
      sclk_base = 1'b1;
      mosi = b;
      waitClk(HALF);
      r = miso_a[sel];
      sclk_base = 1'b0;
      waitClk(HALF);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output logic [2:0][7:0] rxb);
    logic       cpha;
    logic       r;
    logic [7:0] cmd;
    logic [7:0] b;
    rxb = '0;
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    ferr_cnt = 0;
    sel = int'(v.inst);
    cpha = CPHA_V[sel];
    cmd = {v.rd, v.addr};
    cs_act = 1'b1;
    waitClk(HALF);
    for (int i = 7; i >= 0; i--) spiBit(cmd[i], cpha, r);
    checkOutput($sformatf("inst%0d_miso_oe_in_frame", sel), 32'(miso_oe_a[sel]), 32'd1);
    if (v.cut != 0) begin
      b = v.wd[0];
      for (int i = 0; i < int'(v.cut); i++) spiBit(b[7-i], cpha, r);
    end else begin
      for (int w = 0; w < int'(v.nwords); w++) begin
        b = v.rd ? 8'h00 : v.wd[w];
        for (int i = 7; i >= 0; i--) begin
          spiBit(b[i], cpha, r);
          rxb[w][i] = r;
        end
      end
    end
    mosi = 1'b0;
    waitClk(2 * HALF);
    cs_act = 1'b0;
    waitClk(12);
  endtask

  function automatic vec_t mk(input logic [2:0] inst, input logic rd, input logic [6:0] addr,
                              input logic [1:0] nw, input logic [2:0][7:0] wd,
                              input logic [2:0][6:0] ea, input logic [2:0][7:0] ed,
                              input logic [1:0] en, input logic [3:0] cut, input logic ef);
    vec_t v;
    v.inst = inst; v.rd = rd; v.addr = addr; v.nwords = nw; v.wd = wd;
    v.exp_a = ea; v.exp_d = ed; v.exp_n = en; v.cut = cut; v.exp_ferr = ef;
    return v;
  endfunction

  task automatic runVec(input int idx, input vec_t v);
    logic [2:0][7:0] rxb;
    applyStimulus(v, rxb);
    if (v.rd) begin
      checkOutput($sformatf("v%0d_rd_count", idx), 32'(rd_addr_q.size()), 32'(v.exp_n));
      checkOutput($sformatf("v%0d_wr_count", idx), 32'(wr_addr_q.size()), 32'd0);
      for (int k = 0; k < int'(v.exp_n); k++) begin
        if (k < rd_addr_q.size())
          checkOutput($sformatf("v%0d_rd_addr%0d", idx, k), 32'(rd_addr_q[k]), 32'(v.exp_a[k]));
      end
      for (int w = 0; w < int'(v.nwords); w++)
        checkOutput($sformatf("v%0d_miso_byte%0d", idx, w), 32'(rxb[w]), 32'(v.exp_d[w]));
    end else begin
      checkOutput($sformatf("v%0d_wr_count", idx), 32'(wr_addr_q.size()), 32'(v.exp_n));
      for (int k = 0; k < int'(v.exp_n); k++) begin
        if (k < wr_addr_q.size()) begin
          checkOutput($sformatf("v%0d_wr_addr%0d", idx, k), 32'(wr_addr_q[k]), 32'(v.exp_a[k]));
          checkOutput($sformatf("v%0d_wr_data%0d", idx, k), 32'(wr_data_q[k]), 32'(v.exp_d[k]));
        end
      end
    end
    checkOutput($sformatf("v%0d_frame_err", idx), 32'(ferr_cnt), 32'(v.exp_ferr));
    checkOutput($sformatf("v%0d_addr_after", idx), 32'(addr_a[sel]), 32'd0);
    checkOutput($sformatf("v%0d_miso_oe_after", idx), 32'(miso_oe_a[sel]), 32'd0);
  endtask

  initial begin
    logic r;
    logic [7:0] cmd;
    total = 0;
    bad = 0;
    ferr_cnt = 0;
    overlap_cnt = 0;
    sel = 0;
    sclk_base = 1'b0;
    mosi = 1'b0;
    cs_act = 1'b0;
    rst_n = 1'b0;

    vecs[0]  = mk(3'd0, 1'b0, 7'h05, 2'd1, {8'h00, 8'h00, 8'hA5}, {7'h00, 7'h00, 7'h05}, {8'h00, 8'h00, 8'hA5}, 2'd1, 4'd0, 1'b0);
    vecs[1]  = mk(3'd0, 1'b0, 7'h7E, 2'd3, {8'h33, 8'h22, 8'h11}, {7'h00, 7'h7F, 7'h7E}, {8'h33, 8'h22, 8'h11}, 2'd3, 4'd0, 1'b0);
    vecs[2]  = mk(3'd1, 1'b0, 7'h7E, 2'd3, {8'h33, 8'h22, 8'h11}, {7'h7E, 7'h7E, 7'h7E}, {8'h33, 8'h22, 8'h11}, 2'd3, 4'd0, 1'b0);
    vecs[3]  = mk(3'd0, 1'b1, 7'h12, 2'd2, '0, {7'h14, 7'h13, 7'h12}, {8'h00, 8'h43, 8'h42}, 2'd3, 4'd0, 1'b0);
    vecs[4]  = mk(3'd1, 1'b1, 7'h12, 2'd2, '0, {7'h12, 7'h12, 7'h12}, {8'h00, 8'h42, 8'h42}, 2'd3, 4'd0, 1'b0);
    vecs[5]  = mk(3'd2, 1'b0, 7'h05, 2'd1, {8'h00, 8'h00, 8'hA5}, {7'h00, 7'h00, 7'h05}, {8'h00, 8'h00, 8'hA5}, 2'd1, 4'd0, 1'b0);
    vecs[6]  = mk(3'd2, 1'b1, 7'h12, 2'd2, '0, {7'h14, 7'h13, 7'h12}, {8'h00, 8'h43, 8'h42}, 2'd3, 4'd0, 1'b0);
    vecs[7]  = mk(3'd3, 1'b0, 7'h05, 2'd1, {8'h00, 8'h00, 8'hA5}, {7'h00, 7'h00, 7'h05}, {8'h00, 8'h00, 8'hA5}, 2'd1, 4'd0, 1'b0);
    vecs[8]  = mk(3'd3, 1'b1, 7'h12, 2'd2, '0, {7'h14, 7'h13, 7'h12}, {8'h00, 8'h43, 8'h42}, 2'd3, 4'd0, 1'b0);
    vecs[9]  = mk(3'd4, 1'b0, 7'h05, 2'd1, {8'h00, 8'h00, 8'hA5}, {7'h00, 7'h00, 7'h05}, {8'h00, 8'h00, 8'hA5}, 2'd1, 4'd0, 1'b0);
    vecs[10] = mk(3'd4, 1'b1, 7'h12, 2'd2, '0, {7'h14, 7'h13, 7'h12}, {8'h00, 8'h43, 8'h42}, 2'd3, 4'd0, 1'b0);
    vecs[11] = mk(3'd0, 1'b0, 7'h03, 2'd1, {8'h00, 8'h00, 8'hF0}, '0, '0, 2'd0, 4'd5, 1'b1);
    vecs[12] = vecs[0];

    waitClk(4);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("reset_outputs_inst%0d", i),
                  32'({miso_a[i], miso_oe_a[i], addr_a[i], data_wr_a[i], wr_en_a[i], rd_en_a[i], frame_err_a[i]}),
                  32'd0);
    end
    rst_n = 1'b1;
    waitClk(6);

    for (int i = 0; i < 13; i++) runVec(i, vecs[i]);

    // Reset asserted during a read, a third of an sclk period after a leading edge.
    sel = 0;
    cs_act = 1'b1;
    cmd = 8'h92;
    waitClk(HALF);
    for (int i = 7; i >= 0; i--) spiBit(cmd[i], 1'b1, r);
    for (int i = 0; i < 3; i++) spiBit(1'b0, 1'b1, r);
    sclk_base = 1'b1;
    waitClk(5);
    checkOutput("t6_addr_before_reset", 32'(addr_a[0]), 32'h12);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_outputs_at_reset",
                32'({miso_a[0], miso_oe_a[0], addr_a[0], data_wr_a[0], wr_en_a[0], rd_en_a[0], frame_err_a[0]}),
                32'd0);
    waitClk(3);
    sclk_base = 1'b0;
    cs_act = 1'b0;
    waitClk(4);
    rst_n = 1'b1;
    waitClk(6);
    runVec(13, vecs[3]);
    runVec(14, vecs[0]);

    checkOutput("wr_rd_overlap", 32'(overlap_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
